// File: rtl/motor_pkg.sv
// Shared definitions for the two-channel motor ramp scheduler.
package motor_pkg;

  localparam int DUTY_W = 10;

  localparam logic [1:0] MODE_STOP = 2'd0;
  localparam logic [1:0] MODE_FWD  = 2'd1;
  localparam logic [1:0] MODE_BWD  = 2'd2;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_RAMP_UP,
    CH_RUN,
    CH_RAMP_DOWN,
    CH_DEAD
  } chan_state_e;

  // Command code 3 is an alias for stop; the driver never sees it.
  function automatic logic [1:0] canon_mode(input logic [1:0] m);
    case (m)
      MODE_FWD: return MODE_FWD;
      MODE_BWD: return MODE_BWD;
      default:  return MODE_STOP;
    endcase
  endfunction

  function automatic logic chan_locked(input chan_state_e s);
    return (s == CH_RAMP_DOWN) || (s == CH_DEAD);
  endfunction

  function automatic logic chan_busy(input chan_state_e s);
    return (s != CH_IDLE) && (s != CH_RUN);
  endfunction

endpackage

// File: rtl/motor_ramp_chan.sv
// One motor channel: direction mode, tick-paced duty ramp and reversal dead-time.
module motor_ramp_chan
  import motor_pkg::*;
#(
  parameter int RAMP_STEP  = 32,
  parameter int DUTY_MAX   = 650,
  parameter int DEAD_TICKS = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              estop_i,
  input  logic [1:0]        target_i,
  output logic [1:0]        mode_o,
  output logic [DUTY_W-1:0] duty_o,
  output chan_state_e       state_o
);

  localparam int CW = (DEAD_TICKS < 1) ? 1 : $clog2(DEAD_TICKS + 1);
  localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W + 1)'(RAMP_STEP);
  localparam logic [DUTY_W:0]   MAX_X    = (DUTY_W + 1)'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] MAX_D    = DUTY_W'(DUTY_MAX);
  localparam logic [CW-1:0]     DEAD_END = CW'(DEAD_TICKS);

  chan_state_e       state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [DUTY_W:0]   up_x;
  logic [DUTY_W-1:0] dn;
  logic [CW-1:0]     cnt_inc;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    duty_d  = duty_q;
    cnt_d   = cnt_q;
    // Widened add so the clamp sees overflow past DUTY_MAX instead of a wrap.
    up_x    = {1'b0, duty_q} + STEP_X;
    dn      = ({1'b0, duty_q} > STEP_X) ? (duty_q - STEP_X[DUTY_W-1:0]) : '0;
    cnt_inc = cnt_q + 1'b1;

    if (estop_i) begin
      state_d = CH_IDLE;
      mode_d  = MODE_STOP;
      duty_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          mode_d = MODE_STOP;
          duty_d = '0;
          if (target_i != MODE_STOP) begin
            mode_d  = target_i;
            state_d = CH_RAMP_UP;
          end
        end
        CH_RAMP_UP: begin
          if (target_i != mode_q) begin
            state_d = CH_RAMP_DOWN;
          end else if (tick_i) begin
            if (up_x >= MAX_X) begin
              duty_d  = MAX_D;
              state_d = CH_RUN;
            end else begin
              duty_d = up_x[DUTY_W-1:0];
            end
          end
        end
        CH_RUN: begin
          duty_d = MAX_D;
          if (target_i != mode_q) state_d = CH_RAMP_DOWN;
        end
        CH_RAMP_DOWN: begin
          if (tick_i) begin
            duty_d = dn;
            if (dn == '0) begin
              mode_d  = MODE_STOP;
              cnt_d   = '0;
              state_d = (target_i == MODE_STOP) ? CH_IDLE : CH_DEAD;
            end
          end
        end
        CH_DEAD: begin
          mode_d = MODE_STOP;
          duty_d = '0;
          if (tick_i) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEAD_END) begin
              if (target_i == MODE_STOP) begin
                state_d = CH_IDLE;
              end else begin
                mode_d  = target_i;
                state_d = CH_RAMP_UP;
              end
            end
          end
        end
        default: begin
          state_d = CH_IDLE;
          mode_d  = MODE_STOP;
          duty_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      mode_q  <= MODE_STOP;
      duty_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mode_o  = mode_q;
  assign duty_o  = duty_q;
  assign state_o = state_q;

endmodule

// File: rtl/motor_ramp_sched.sv
// Two-motor ramp scheduler: tick prescaler, command handshake, estop fan-out.
module motor_ramp_sched
  import motor_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int RAMP_STEP  = 32,
  parameter int DUTY_MAX   = 650,
  parameter int DEAD_TICKS = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_l_mode,
  input  logic [1:0]        cmd_r_mode,
  input  logic              estop,
  output logic [1:0]        l_mode,
  output logic [1:0]        r_mode,
  output logic [DUTY_W-1:0] l_duty,
  output logic [DUTY_W-1:0] r_duty,
  output logic              busy
);

  localparam int TW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick;
  logic [1:0]    tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic          accept;
  chan_state_e   l_state, r_state;

  always_comb begin
    tick   = (tcnt_q == TICK_LAST);
    tcnt_d = tick ? '0 : tcnt_q + 1'b1;
  end

  assign cmd_ready = !estop && !(chan_locked(l_state) || chan_locked(r_state));
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = chan_busy(l_state) || chan_busy(r_state);

  // Channels are fed the next-cycle target so they react on the acceptance edge.
  always_comb begin
    tgt_l_d = tgt_l_q;
    tgt_r_d = tgt_r_q;
    if (estop) begin
      tgt_l_d = MODE_STOP;
      tgt_r_d = MODE_STOP;
    end else if (accept) begin
      tgt_l_d = canon_mode(cmd_l_mode);
      tgt_r_d = canon_mode(cmd_r_mode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q  <= '0;
      tgt_l_q <= MODE_STOP;
      tgt_r_q <= MODE_STOP;
    end else begin
      tcnt_q  <= tcnt_d;
      tgt_l_q <= tgt_l_d;
      tgt_r_q <= tgt_r_d;
    end
  end

  motor_ramp_chan #(
    .RAMP_STEP  (RAMP_STEP),
    .DUTY_MAX   (DUTY_MAX),
    .DEAD_TICKS (DEAD_TICKS)
  ) u_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .estop_i  (estop),
    .target_i (tgt_l_d),
    .mode_o   (l_mode),
    .duty_o   (l_duty),
    .state_o  (l_state)
  );

  motor_ramp_chan #(
    .RAMP_STEP  (RAMP_STEP),
    .DUTY_MAX   (DUTY_MAX),
    .DEAD_TICKS (DEAD_TICKS)
  ) u_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .estop_i  (estop),
    .target_i (tgt_r_d),
    .mode_o   (r_mode),
    .duty_o   (r_duty),
    .state_o  (r_state)
  );

endmodule

// File: tb/tb_motor_ramp_sched.sv
// Self-checking bench: behavioural per-channel model plus directed and random stimulus.
module tb_motor_ramp_sched;

  localparam int TD   = 4;
  localparam int STEP = 256;
  localparam int MAX  = 650;
  localparam int DT   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_l_mode, cmd_r_mode;
  logic       estop;
  logic [1:0] l_mode, r_mode;
  logic [9:0] l_duty, r_duty;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  always #5 clk = ~clk;

  motor_ramp_sched #(
    .TICK_DIV   (TD),
    .RAMP_STEP  (STEP),
    .DUTY_MAX   (MAX),
    .DEAD_TICKS (DT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_l_mode (cmd_l_mode),
    .cmd_r_mode (cmd_r_mode),
    .estop      (estop),
    .l_mode     (l_mode),
    .r_mode     (r_mode),
    .l_duty     (l_duty),
    .r_duty     (r_duty),
    .busy       (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A channel is described by its driven direction, duty, remaining dead ticks
  // and whether it is winding down; phases are implied by those quantities.
  typedef struct packed {
    int mode;
    int duty;
    int dead;
    bit down;
  } ch_t;

  ch_t md[2];
  int  md_tgt[2];
  int  md_cnt;
  int  m_w[2];
  bit  m_tick, m_ready, m_busy, m_acc;

  function automatic int canon(input logic [1:0] m);
    return (m == 2'd3) ? 0 : int'(m);
  endfunction

  function automatic ch_t ch_next(input ch_t c, input int w, input bit tk, input bit es);
    ch_t n = c;
    if (es) begin
      n = '0;
    end else if (c.dead > 0) begin
      if (tk) begin
        n.dead = c.dead - 1;
        if (n.dead == 0) n.mode = w;
      end
    end else if (c.down) begin
      if (tk) begin
        n.duty = (c.duty > STEP) ? c.duty - STEP : 0;
        if (n.duty == 0) begin
          n.mode = 0;
          n.down = 0;
          n.dead = (w != 0) ? DT : 0;
        end
      end
    end else if (c.mode == 0) begin
      n.mode = w;
    end else if (w != c.mode) begin
      n.down = 1;
    end else if (tk) begin
      n.duty = (c.duty + STEP > MAX) ? MAX : c.duty + STEP;
    end
    return n;
  endfunction

  always_comb begin
    m_tick  = (md_cnt == TD - 1);
    m_ready = !estop;
    m_busy  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (md[c].down || md[c].dead > 0) begin
        m_ready = 1'b0;
        m_busy  = 1'b1;
      end
      if (md[c].mode != 0 && !md[c].down && md[c].duty < MAX) m_busy = 1'b1;
    end
    m_acc  = cmd_valid && m_ready;
    m_w[0] = estop ? 0 : (m_acc ? canon(cmd_l_mode) : md_tgt[0]);
    m_w[1] = estop ? 0 : (m_acc ? canon(cmd_r_mode) : md_tgt[1]);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt    <= 0;
      md[0]     <= '0;
      md[1]     <= '0;
      md_tgt[0] <= 0;
      md_tgt[1] <= 0;
    end else begin
      md_cnt    <= m_tick ? 0 : md_cnt + 1;
      md[0]     <= ch_next(md[0], m_w[0], m_tick, estop);
      md[1]     <= ch_next(md[1], m_w[1], m_tick, estop);
      md_tgt[0] <= m_w[0];
      md_tgt[1] <= m_w[1];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("l_mode",    int'(l_mode),    md[0].mode);
      chk("r_mode",    int'(r_mode),    md[1].mode);
      chk("l_duty",    int'(l_duty),    md[0].duty);
      chk("r_duty",    int'(r_duty),    md[1].duty);
      chk("busy",      int'(busy),      int'(m_busy));
      chk("cmd_ready", int'(cmd_ready), int'(m_ready));
    end
  end

  // ---------------- change histories for literal sequence checks ----------------
  int lhist[$];
  int rhist[$];
  int lmhist[$];
  int last_l = 0, last_r = 0, last_lm = 0;
  bit seen3 = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(l_duty) != last_l) lhist.push_back(int'(l_duty));
      if (int'(r_duty) != last_r) rhist.push_back(int'(r_duty));
      if (int'(l_mode) != last_lm) lmhist.push_back(int'(l_mode));
      last_l  <= int'(l_duty);
      last_r  <= int'(r_duty);
      last_lm <= int'(l_mode);
      if (l_mode == 2'd3 || r_mode == 2'd3) seen3 <= 1'b1;
    end
  end

  task automatic chk_seq(input string nm, input int q[$], input int start, input int exp[$]);
    chk({nm, "_len"}, q.size() - start, exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(nm, (start + i < q.size()) ? q[start + i] : -1, exp[i]);
  endtask

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic send(input logic [1:0] l, input logic [1:0] r, output int waited);
    int n = 0;
    cmd_l_mode = l;
    cmd_r_mode = r;
    cmd_valid  = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", (n < 200) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    waited = n;
  endtask

  task automatic wait_settled();
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("settle_timeout", (n < 300) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lduty(input int v);
    int n = 0;
    while (int'(l_duty) != v && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("lduty_wait_timeout", (n < 200) ? 1 : 0, 1);
  endtask

  task automatic wait_lmode(input int v);
    int n = 0;
    while (int'(l_mode) != v && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("lmode_wait_timeout", (n < 200) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1);
  end

  initial begin
    int w, s, rs, ms, k;
    rst_n = 1'b0; cmd_valid = 1'b0; estop = 1'b0;
    cmd_l_mode = 2'd0; cmd_r_mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_l_mode", int'(l_mode), 0);
    chk("rst_r_mode", int'(r_mode), 0);
    chk("rst_l_duty", int'(l_duty), 0);
    chk("rst_r_duty", int'(r_duty), 0);
    chk("rst_ready",  int'(cmd_ready), 1);
    chk("rst_busy",   int'(busy), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // 1: both forward from idle
    s = lhist.size();
    send(2'd1, 2'd1, w);
    chk("s1_l_mode_next", int'(l_mode), 1);
    chk("s1_r_mode_next", int'(r_mode), 1);
    chk("s1_l_duty_next", int'(l_duty), 0);
    wait_settled();
    chk_seq("s1_lduty", lhist, s, '{256, 512, 650});
    chk("s1_busy_end", int'(busy), 0);

    // 2: left reverses, right holds
    s = lhist.size(); rs = rhist.size(); ms = lmhist.size();
    send(2'd2, 2'd1, w);
    @(negedge clk);
    chk("s2_ready_after_acc", int'(cmd_ready), 0);
    wait_settled();
    chk_seq("s2_lduty", lhist, s, '{394, 138, 0, 256, 512, 650});
    chk_seq("s2_lmode", lmhist, ms, '{0, 2});
    chk("s2_r_unchanged", rhist.size() - rs, 0);
    chk("s2_r_mode", int'(r_mode), 1);

    // 3: code 3 / 0 stops both
    s = lhist.size(); rs = rhist.size();
    send(2'd3, 2'd0, w);
    wait_settled();
    chk_seq("s3_lduty", lhist, s, '{394, 138, 0});
    chk_seq("s3_rduty", rhist, rs, '{394, 138, 0});
    chk("s3_l_mode", int'(l_mode), 0);
    chk("s3_no_mode3", int'(seen3), 0);

    // 4: estop mid ramp-up
    send(2'd1, 2'd1, w);
    wait_lduty(512);
    estop = 1'b1;
    @(negedge clk);
    chk("s4_ready_estop", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("s4_l_duty", int'(l_duty), 0);
    chk("s4_l_mode", int'(l_mode), 0);
    chk("s4_r_duty", int'(r_duty), 0);
    chk("s4_busy",   int'(busy), 0);
    estop = 1'b0;
    @(negedge clk);
    chk("s4_ready_after", int'(cmd_ready), 1);
    @(posedge clk); #1;

    // 5: command held during dead-time
    send(2'd1, 2'd1, w);
    wait_settled();
    send(2'd2, 2'd1, w);
    wait_lmode(0);
    send(2'd2, 2'd1, w);
    chk("s5_wait_cycles", w, DT * TD);
    chk("s5_l_mode", int'(l_mode), 2);
    chk("s5_l_duty", int'(l_duty), 0);
    wait_settled();

    // 6: async reset mid ramp-down, tick restarts from zero
    send(2'd0, 2'd0, w);
    wait_lduty(394);
    #3;
    rst_n = 1'b0;
    #1;
    chk("s6_l_duty", int'(l_duty), 0);
    chk("s6_r_duty", int'(r_duty), 0);
    chk("s6_l_mode", int'(l_mode), 0);
    chk("s6_r_mode", int'(r_mode), 0);
    chk("s6_busy",   int'(busy), 0);
    chk("s6_ready",  int'(cmd_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmd_l_mode = 2'd1; cmd_r_mode = 2'd1; cmd_valid = 1'b1;
    k = 0;
    while (int'(l_duty) != 256 && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) cmd_valid = 1'b0;
    end
    chk("s6_first_tick", k, TD);
    wait_settled();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_l_mode = 2'($urandom_range(0, 3));
      cmd_r_mode = 2'($urandom_range(0, 3));
      estop      = ($urandom_range(0, 59) == 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    estop     = 1'b0;
    wait_settled();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_ramp_sched.md
Name: motor_ramp_sched

Overview:
Sequences the two drive motors of the car. Accepts left/right motion commands over a valid/ready handshake and produces per-motor direction mode and PWM duty. Every speed change is a tick-paced duty ramp. Every direction reversal inserts ramp-down, then a dead-time with both H-bridge inputs off, then ramp-up. Sits between the navigation FSM and the motor driver: l_mode/r_mode drive the driver's direction decode, l_duty/r_duty drive the per-motor PWM generators.

Parameters:
TICK_DIV, 100000, clk cycles per ramp tick (1 ms at 100 MHz)
RAMP_STEP, 32, duty change per tick while ramping
DUTY_MAX, 650, run duty (10-bit, out of 1024)
DEAD_TICKS, 20, ticks with mode=0, duty=0 between opposite directions

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready
cmd_l_mode  in  2  left target: 0 stop, 1 forward, 2 backward, 3 stop
cmd_r_mode  in  2  right target, same encoding
estop  in  1  synchronous emergency stop, level
l_mode  out  2  left direction to driver (0/1/2 only)
r_mode  out  2  right direction to driver
l_duty  out  10  left PWM duty
r_duty  out  10  right PWM duty
busy  out  1  either channel not in IDLE or RUN

Behaviour:
- Reset (rst_n low, async): tick counter=0; both channels IDLE; l_mode=r_mode=0; l_duty=r_duty=0; targets=0; cmd_ready=1; busy=0.
- Tick: free-running counter 0..TICK_DIV-1. tick=1 for one cycle when count==TICK_DIV-1, then count wraps to 0. Duty changes and dead-time counting occur only on tick.
- Target 3 is canonicalised to 0 on acceptance. Output mode is never 3.
- cmd_ready = !estop && neither channel in RAMP_DOWN or DEAD.
- On acceptance, both targets latch in the same cycle. Each channel reacts from the next cycle.
- Per-channel FSM, states IDLE, RAMP_UP, RUN, RAMP_DOWN, DEAD:
  - IDLE: mode=0, duty=0. Nonzero target: mode=target immediately (next cycle), go to RAMP_UP.
  - RAMP_UP:
    - On tick: duty=min(duty+RAMP_STEP, DUTY_MAX). Reaching DUTY_MAX goes to RUN on the same tick.
    - Target 0 or opposite direction accepted: go to RAMP_DOWN.
  - RUN: duty=DUTY_MAX. Target 0 or opposite direction: go to RAMP_DOWN.
  - Same-direction target in RAMP_UP/RUN: no effect.
  - RAMP_DOWN:
    - On tick: duty = duty>RAMP_STEP ? duty-RAMP_STEP : 0.
    - On the tick duty reaches 0: mode=0. Go to IDLE if target==0, else to DEAD with dead counter=0.
  - DEAD: mode=0, duty=0. Counter increments per tick. On the tick it reaches DEAD_TICKS: mode=target, go to RAMP_UP.
- Arithmetic: duty add done at 11 bits and clamped, so there is no 10-bit wrap. Subtraction never underflows.
- estop high: next cycle both channels go to IDLE with mode=0, duty=0, targets cleared. cmd_ready=0 while high. The tick counter is unaffected.
- Simultaneous cmd accept and estop is impossible (ready low).
- Channels are independent apart from the shared tick and the shared cmd_ready. busy = OR of per-channel not-IDLE/RUN.

Decomposition:
- Shared package motor_pkg: mode constants MODE_STOP=0, MODE_FWD=1, MODE_BWD=2; channel state enum; 10-bit duty width constant.
- Sub-module motor_ramp_chan: one-channel FSM with duty register and dead counter. Instantiated twice.
- Top-level holds the tick prescaler, handshake and estop fan-out.

Test Plan:
Bench parameters: TICK_DIV=4, RAMP_STEP=256, DUTY_MAX=650, DEAD_TICKS=2.
1. Reset release; cmd l=1, r=1 accepted -> modes 1/1 next cycle; duty 256, 512, 650 on three successive ticks; RUN; busy falls after the third tick.
2. From RUN, cmd l=2, r=1 -> left duty 394, 138, 0 with mode 0 at 0; 2 ticks dead; mode 2; ramp 256, 512, 650. cmd_ready low from the cycle after acceptance until left enters RAMP_UP. Right stays 1/650 throughout.
3. From RUN, cmd l=3, r=0 -> both ramp 650→394→138→0, modes 0, IDLE; l_mode never shows 3.
4. Mid RAMP_UP (duty 512) assert estop one cycle -> next cycle duty 0, mode 0, IDLE; cmd_ready low during estop, high after.
5. Hold cmd_valid with a new command during DEAD -> not accepted until dead ends; accepted the first cycle cmd_ready=1.
6. Assert rst_n low mid RAMP_DOWN, asynchronously between clock edges -> outputs 0 immediately without a clock edge; after release, tick resumes from count 0.
